// File: rtl/cnt_pkg.sv
// Shared constants and readout-state type for the cascaded-count capture block.
package cnt_pkg;
  localparam int CNT_W  = 64;
  localparam int WORD_W = 16;
  localparam int NWORDS = CNT_W / WORD_W;

  typedef enum logic {IDLE, SEND} rd_state_t;

  function automatic logic [WORD_W-1:0] word_of(input logic [CNT_W-1:0] e, input logic [1:0] i);
    return e[WORD_W*int'(i) +: WORD_W];
  endfunction
endpackage

// File: rtl/cnt_capture_fifo.sv
// Synchronous capture FIFO; exposes the head and the entry behind it so the
// serialiser can switch entries without a bubble.
module cnt_capture_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               head,
  output logic [W-1:0]               head_next,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;

  assign rd_ptr_nxt = rd_ptr + AW'(1);
  assign head       = mem[rd_ptr];
  assign head_next  = mem[rd_ptr_nxt];
  assign full       = (level == (AW+1)'(DEPTH));
  assign empty      = (level == '0);

  // Storage is not reset; validity is carried entirely by the pointers/level.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr_nxt;
      case ({wr_en, rd_en})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/cnt_capture.sv
// Captures the 64-bit cascaded count on trig and serialises each entry as four
// 16-bit words (LS first) over a valid/ready stream.
module cnt_capture
  import cnt_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [63:0]             cnt,
  input  logic                    trig,
  input  logic                    clr_ovf,
  output logic [WORD_W-1:0]       dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf
);
  rd_state_t        state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] head, head_next;
  logic             full, empty, pop, free, wr, drop;

  // A full FIFO still accepts a capture when the head's last word leaves on the same edge.
  assign pop  = (state == SEND) && dout_ready && (idx == 2'd3);
  assign free = !full || pop;
  assign wr   = trig && free;
  assign drop = trig && !free;

  cnt_capture_fifo #(.DEPTH(DEPTH), .W(CNT_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr),
    .wr_data   (cnt),
    .rd_en     (pop),
    .head      (head),
    .head_next (head_next),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;

      case (state)
        IDLE: if (!empty) begin
          state      <= SEND;
          idx        <= 2'd0;
          dout       <= word_of(head, 2'd0);
          dout_valid <= 1'b1;
          dout_last  <= 1'b0;
        end
        SEND: if (dout_ready) begin
          if (idx != 2'd3) begin
            idx       <= idx + 2'd1;
            dout      <= word_of(head, idx + 2'd1);
            dout_last <= (idx == 2'd2);
          end else if (level > 1) begin
            idx       <= 2'd0;
            dout      <= word_of(head_next, 2'd0);
            dout_last <= 1'b0;
          end else begin
            state      <= IDLE;
            idx        <= 2'd0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
